// File: rtl/wdata_burst_reader.sv
// -----------------------------------------------------------------------------
// wdata_burst_reader
//
// Drains one write burst from the write-data sync_fifo per accepted command and
// hands the beats to the PHY write-data path. Popped beats land in a 2-entry
// output buffer, so popping and downstream backpressure are decoupled while
// still sustaining one beat per cycle.
//
// Parameters
//   DATA_W          beat width (must match the FIFO data width)
//   LEN_W           burst length field width; max burst is 2**LEN_W beats
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   cmd_valid_i     burst command valid
//   cmd_len_i       burst length minus one
//   cmd_ready_o     command accepted when high together with cmd_valid_i
//   fifo_rd_ready_i FIFO head valid
//   fifo_data_i     FIFO head beat
//   fifo_rd_o       pop strobe to the FIFO
//   wdata_o         output beat (buffer head)
//   wdata_valid_o   output beat valid
//   wdata_last_o    output beat is the final beat of the burst
//   wdata_ready_i   downstream accepts the beat
//   busy_o          burst in progress
//   done_o          one-cycle pulse after the last beat handshake
// -----------------------------------------------------------------------------
module wdata_burst_reader #(
  parameter int DATA_W = 64,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  output logic              cmd_ready_o,
  input  logic              fifo_rd_ready_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              fifo_rd_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              wdata_valid_o,
  output logic              wdata_last_o,
  input  logic              wdata_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [LEN_W-1:0]    r_len;
  logic [LEN_W:0]      r_pop_cnt;   // one extra bit: counts up to 2**LEN_W pops
  logic [LEN_W:0]      r_out_cnt;
  logic [DATA_W-1:0]   r_buf [2];
  logic                r_head;
  logic                r_tail;
  logic [1:0]          r_occ;
  logic                r_done;

  logic                w_cmd_hs;
  logic                w_pop;
  logic                w_buf_valid;
  logic                w_out_hs;
  logic                w_last;
  logic                w_more_pops;

  assign w_buf_valid = (r_occ != 2'd0);
  assign w_last      = w_buf_valid & (r_out_cnt == {1'b0, r_len});
  assign w_out_hs    = w_buf_valid & wdata_ready_i;
  assign w_more_pops = (r_pop_cnt <= {1'b0, r_len});
  assign w_cmd_hs    = cmd_valid_i & cmd_ready_o;
  assign w_pop       = fifo_rd_o & fifo_rd_ready_i;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable written in a combinational process gets a default
  // first, otherwise an unassigned path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (cmd_valid_i)         w_state_nxt = S_RUN;
      S_RUN:  if (w_out_hs && w_last)  w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // A pop is allowed when the buffer has room, or when the head leaves in the
  // same cycle so the freed slot is refilled without a bubble.
  always_comb begin
    cmd_ready_o   = 1'b0;
    busy_o        = 1'b0;
    fifo_rd_o     = 1'b0;
    unique case (r_state)
      S_IDLE: cmd_ready_o = 1'b1;
      S_RUN: begin
        busy_o    = 1'b1;
        fifo_rd_o = fifo_rd_ready_i & w_more_pops &
                    ((r_occ < 2'd2) | w_out_hs);
      end
      default: ;
    endcase
    wdata_o       = r_buf[r_head];
    wdata_valid_o = w_buf_valid;
    wdata_last_o  = w_last;
    done_o        = r_done;
  end

  // ---------------------------------------------------------------------------
  // Datapath: burst bookkeeping and 2-entry output buffer
  // ---------------------------------------------------------------------------
  // NOTE: the two buffer entries are reset because wdata_o exposes the head
  // directly and must read zero out of reset; a deep memory would not be reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len     <= '0;
      r_pop_cnt <= '0;
      r_out_cnt <= '0;
      r_buf[0]  <= '0;
      r_buf[1]  <= '0;
      r_head    <= 1'b0;
      r_tail    <= 1'b0;
      r_occ     <= 2'd0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == S_RUN) & w_out_hs & w_last;

      if (w_cmd_hs) begin
        r_len     <= cmd_len_i;
        r_pop_cnt <= '0;
        r_out_cnt <= '0;
      end

      if (w_pop) begin
        r_buf[r_tail] <= fifo_data_i;
        r_tail        <= ~r_tail;
        r_pop_cnt     <= r_pop_cnt + 1'b1;
      end

      if (w_out_hs) begin
        r_head    <= ~r_head;
        r_out_cnt <= r_out_cnt + 1'b1;
      end

      // Simultaneous pop and drain leaves the occupancy unchanged.
      unique case ({w_pop, w_out_hs})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: doc/wdata_burst_reader.md
# wdata_burst_reader

Read-side drain engine for the LPDDR4 controller's write-data `sync_fifo`. It pops beats from the FIFO's read port (`rd_i`/`rd_ready_o`/`data_o`) once a burst command is accepted. Popped beats are held in a 2-entry output buffer and presented to the PHY write-data path on a valid/ready interface, with `last` flagged on the final beat. It is the consumer at the other end of the FIFO interface; the command scheduler issues one command per write burst.

## Interface
- `DATA_W`, 64: beat width; must equal the FIFO `DDR_DATA_W`.
- `LEN_W`, 4: width of the burst length field. Maximum burst is 2^LEN_W beats.
- `clk` input 1: clock.
- `rst_n` input 1: reset; asynchronous, active-low.
- `cmd_valid_i` input 1: burst command valid.
- `cmd_len_i` input LEN_W: burst length minus 1 (0 means 1 beat).
- `cmd_ready_o` output 1: command accepted when high with `cmd_valid_i`.
- `fifo_rd_ready_i` input 1: connects to FIFO `rd_ready_o`; combinational, head data valid.
- `fifo_data_i` input DATA_W: connects to FIFO `data_o`; head beat, valid while `fifo_rd_ready_i` is high.
- `fifo_rd_o` output 1: pop strobe to FIFO `rd_i`; a beat is consumed when `fifo_rd_o & fifo_rd_ready_i`.
- `wdata_o` output DATA_W: output beat.
- `wdata_valid_o` output 1: output beat valid.
- `wdata_last_o` output 1: final beat of the burst.
- `wdata_ready_i` input 1: downstream accepts the beat.
- `busy_o` output 1: high while not in IDLE.
- `done_o` output 1: one-cycle pulse, registered, in the cycle after the last beat handshake.

## Operation
- FSM states: IDLE and RUN.
- **IDLE**
  - `cmd_ready_o`=1 (combinational, state only).
  - On `cmd_valid_i`: latch `len`=`cmd_len_i`, clear `pop_cnt` and `out_cnt` (each LEN_W+1 bits), go to RUN.
- **RUN**
  - `cmd_ready_o`=0.
  - `fifo_rd_o` = `fifo_rd_ready_i` & (`pop_cnt` <= `len`) & (`occ` < 2 | `out_hs`).
  - `out_hs` = `wdata_valid_o` & `wdata_ready_i`.
  - `fifo_rd_o` never asserts without `fifo_rd_ready_i` and never asserts after len+1 pops.
  - Each pop writes `fifo_data_i` into the buffer tail, and `pop_cnt` increments.
  - Buffer is a 2-entry FIFO with `occ` in 0..2. Order is strictly preserved.
  - Simultaneous pop and drain: `occ` unchanged; head advances, tail written.
  - `wdata_valid_o` = (`occ` != 0). `wdata_o` is the buffer head, stable while valid and not ready.
  - `wdata_last_o` = `wdata_valid_o` & (`out_cnt` == `len`).
  - Each `out_hs` increments `out_cnt`.
  - On `out_hs` with `wdata_last_o` set: go to IDLE, set `done_o` next cycle. `occ` is 0 at that point by construction.
- FIFO starvation (`fifo_rd_ready_i` low) stalls popping only. Buffered beats still drain.
- Commands presented during RUN are held off (`cmd_ready_o`=0). There is at least one IDLE cycle between bursts.
- Reset, including mid-burst: all state cleared and the FSM returns to IDLE. Beats already popped are discarded; the FIFO is reset by the same `rst_n`.

## Timing
- Reset values:
  - `cmd_ready_o`=1, `fifo_rd_o`=0, `wdata_valid_o`=0, `wdata_last_o`=0, `busy_o`=0, `done_o`=0.
  - `wdata_o`=0, `occ`=0, `pop_cnt`=0, `out_cnt`=0, `len`=0.
- Command accepted at edge T. `fifo_rd_o` may assert in cycle T+1.
- Pop at cycle N gives `wdata_valid_o` at N+1 (1-cycle latency).
- Throughput is 1 beat/cycle with FIFO non-empty and downstream always ready.
- An L-beat burst with no stalls:
  - pops in cycles T+1..T+L;
  - outputs in T+2..T+L+1;
  - `done_o` in T+L+2;
  - `cmd_ready_o` high again in T+L+2.
- `done_o` is high for exactly 1 cycle per burst.

## Test plan
- **Single beat:** `cmd_len_i`=0, FIFO holds 0xA5. Required:
  - exactly one `fifo_rd_o` pulse;
  - one output beat 0xA5 with `wdata_last_o`=1;
  - `done_o` 1 cycle later.
- **Full burst streaming:** `cmd_len_i`=15, FIFO preloaded with 0..15, ready always high. Required:
  - 16 consecutive output beats 0..15, last on beat 15;
  - exactly 16 pops;
  - `done_o` at T+18.
- **Backpressure:** `cmd_len_i`=7, `wdata_ready_i` toggling 1-0-0-1. Required:
  - `occ` never exceeds 2;
  - `wdata_o` stable while stalled;
  - output order 0..7 intact;
  - no pop while `occ`=2 without a drain.
- **Starvation:** `cmd_len_i`=3, FIFO gets beats 1, 2 at T+1, then nothing for 5 cycles, then 3, 4. Required:
  - `fifo_rd_o` low while the FIFO is empty;
  - outputs 1, 2, gap, 3, 4;
  - last on 4;
  - no pops beyond 4 even if the FIFO has more data.
- **Back-to-back commands:** `cmd_valid_i` held high for lengths 1 then 2 (encoded 0, 1). Required:
  - second command accepted only after the first `done_o` cycle;
  - total pops = 3;
  - `wdata_last_o` seen twice.
- **Reset mid-burst:** `cmd_len_i`=7, assert `rst_n` low after 3 output beats. Required:
  - all outputs return to reset values immediately;
  - after release `cmd_ready_o`=1;
  - a new burst `cmd_len_i`=1 completes correctly.
